// File: rtl/score_tick_timer_if.sv
// Round-timer bundle between the game side and the score tick timer.
// Latency: n/a (wires only).
// Backpressure: none; start/pause are levels, tick/time_up are single-cycle pulses.
//
// Signals:
//   slow_clk  toggling tick source from the score clock divider (async to clk)
//   start     level, (re)loads and runs the timer while high
//   pause     level, freezes the countdown while high
//   tick      one-cycle pulse per synchronised slow_clk rising edge
//   tens/ones BCD countdown digits
//   running   high while counting
//   done      high once the round has expired, until start or reset
//   time_up   one-cycle pulse on entry to the expired state
interface score_tick_timer_if;
    logic       slow_clk;
    logic       start;
    logic       pause;
    logic       tick;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       done;
    logic       time_up;

    // Game side: drives the controls, observes the timer.
    modport master (
        output slow_clk,
        output start,
        output pause,
        input  tick,
        input  tens,
        input  ones,
        input  running,
        input  done,
        input  time_up
    );

    // Timer side.
    modport slave (
        input  slow_clk,
        input  start,
        input  pause,
        output tick,
        output tens,
        output ones,
        output running,
        output done,
        output time_up
    );
endinterface

// File: rtl/score_tick_timer.sv
// Whack-a-mole round timer: synchronises slow_clk into clk, makes one tick per rising edge, runs a 2-digit BCD countdown.
// Latency: slow_clk rise sampled at edge N -> tick high after edge N+SYNC_STAGES -> digits update at edge N+SYNC_STAGES+1.
// Backpressure: none; start has priority over pause, which has priority over tick; ticks outside RUN are dropped.
//
// Ports:
//   clk    system clock (100 MHz)
//   reset  asynchronous, active-high; returns to IDLE with the initial digits loaded
//   tmr    score_tick_timer_if.slave: slow_clk/start/pause in; tick/tens/ones/running/done/time_up out
module score_tick_timer #(
    parameter logic [3:0] TENS_INIT   = 4'd6,
    parameter logic [3:0] ONES_INIT   = 4'd0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    score_tick_timer_if.slave tmr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Number of cycles after reset release during which the edge detector
    // output is ignored: the chain and history flop need that long to fill
    // with the real slow_clk level, otherwise a slow_clk that is already
    // high at release would look like a rising edge.
    localparam int PRIME_CYCLES = SYNC_STAGES + 1;
    localparam int PRIME_W      = $clog2(PRIME_CYCLES + 1);

    // A zero-length round never enters RUN: start goes straight to DONE.
    localparam logic ZERO_ROUND = (TENS_INIT == 4'd0) && (ONES_INIT == 4'd0);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [PRIME_W-1:0]     prime_cnt;
    logic                   primed;
    logic                   rise;
    state_t                 state;

    assign primed = (prime_cnt == PRIME_W'(PRIME_CYCLES));
    assign rise   = sync_q[SYNC_STAGES-1] & ~hist_q;

    // ------------------------------------------------------------------
    // slow_clk synchroniser, edge detector and tick register.
    // sync_q[0] is the metastability-catching stage; only the last stage
    // and the history flop feed logic.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            hist_q    <= 1'b0;
            prime_cnt <= '0;
            tmr.tick  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], tmr.slow_clk};
            hist_q   <= sync_q[SYNC_STAGES-1];
            tmr.tick <= rise & primed;
            if (!primed) begin
                prime_cnt <= prime_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round FSM with BCD countdown. running/done/time_up are registered
    // alongside the state so they change on the same edge as the state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            tmr.tens    <= TENS_INIT;
            tmr.ones    <= ONES_INIT;
            tmr.running <= 1'b0;
            tmr.done    <= 1'b0;
            tmr.time_up <= 1'b0;
        end else begin
            tmr.time_up <= 1'b0;

            if (tmr.start) begin
                // Reload from any state. Holding start keeps reloading, so
                // the count cannot advance until start drops.
                tmr.tens <= TENS_INIT;
                tmr.ones <= ONES_INIT;
                if (ZERO_ROUND) begin
                    state       <= S_DONE;
                    tmr.running <= 1'b0;
                    tmr.done    <= 1'b1;
                    // Pulse only on entry, not while already expired.
                    tmr.time_up <= (state != S_DONE);
                end else begin
                    state       <= S_RUN;
                    tmr.running <= 1'b1;
                    tmr.done    <= 1'b0;
                end
            end else begin
                case (state)
                    S_RUN: begin
                        if (tmr.pause) begin
                            // A tick coinciding with pause is dropped.
                            state       <= S_PAUSED;
                            tmr.running <= 1'b0;
                        end else if (tmr.tick) begin
                            if (tmr.tens == 4'd0 && tmr.ones == 4'd1) begin
                                // Final decrement and DONE entry on one edge.
                                tmr.ones    <= 4'd0;
                                state       <= S_DONE;
                                tmr.running <= 1'b0;
                                tmr.done    <= 1'b1;
                                tmr.time_up <= 1'b1;
                            end else if (tmr.ones == 4'd0) begin
                                // Borrow from tens; 00 is unreachable in RUN,
                                // the guard only keeps the digits in 0..9.
                                if (tmr.tens != 4'd0) begin
                                    tmr.ones <= 4'd9;
                                    tmr.tens <= tmr.tens - 4'd1;
                                end
                            end else begin
                                tmr.ones <= tmr.ones - 4'd1;
                            end
                        end
                    end

                    S_PAUSED: begin
                        if (!tmr.pause) begin
                            state       <= S_RUN;
                            tmr.running <= 1'b1;
                        end
                    end

                    S_IDLE, S_DONE: begin
                        // Hold until start.
                    end

                    default: begin
                        state       <= S_IDLE;
                        tmr.running <= 1'b0;
                        tmr.done    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A decrement at 00 would mean DONE was missed.
    a_no_decrement_at_zero : assert property (
        @(posedge clk) disable iff (reset)
        !(state == S_RUN && !tmr.start && !tmr.pause && tmr.tick &&
          tmr.tens == 4'd0 && tmr.ones == 4'd0)
    );

endmodule

// File: tb/tb_score_tick_timer.sv
// Self-checking bench for score_tick_timer: a default 60-count instance and a zero-length-round instance.
// Latency: stimulus is driven and outputs sampled on the falling clk edge.
// Backpressure: none; slow_clk periods are generated by the bench (10 cycles high, 10 low).
module tb_score_tick_timer;

    logic clk;
    logic reset;

    int n_vec = 0;
    int n_err = 0;

    score_tick_timer_if bus ();
    score_tick_timer_if bus0 ();

    score_tick_timer dut (
        .clk   (clk),
        .reset (reset),
        .tmr   (bus)
    );

    score_tick_timer #(
        .TENS_INIT (4'd0),
        .ONES_INIT (4'd0)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .tmr   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {OP_TICK, OP_PAUSE_ON, OP_PAUSE_OFF, OP_START} op_t;

    typedef struct {
        op_t  op;
        int   reps;
        int   exp_cnt;
        logic exp_run;
        logic exp_done;
        int   exp_tu;
    } vec_t;

    vec_t vecs [12];

    int   model_cnt;
    logic model_run;
    logic pause_m;

    int   tu_cnt    = 0;
    logic done_prev = 1'b0;
    int   tu0_cnt   = 0;
    logic run0_seen = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string name, input int exp);
        chk({name, " tens"}, {4'd0, bus.tens}, 8'(exp / 10));
        chk({name, " ones"}, {4'd0, bus.ones}, 8'(exp % 10));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic slow_period();
        bus.slow_clk = 1'b1;
        repeat (10) step();
        bus.slow_clk = 1'b0;
        repeat (10) step();
    endtask

    // time_up must coincide with done rising, with running low.
    always @(negedge clk) begin
        if (bus.time_up === 1'b1) begin
            tu_cnt++;
            chk("time_up vs done/running/done_prev",
                {5'd0, bus.done, bus.running, done_prev}, 8'b100);
        end
        done_prev = bus.done;
        if (bus0.time_up === 1'b1) tu0_cnt++;
        if (bus0.running === 1'b1) run0_seen = 1'b1;
    end

    initial begin
        vecs[0]  = '{OP_TICK,      14, 45, 1'b1, 1'b0, 0};
        vecs[1]  = '{OP_PAUSE_ON,   0, 45, 1'b0, 1'b0, 0};
        vecs[2]  = '{OP_TICK,       3, 45, 1'b0, 1'b0, 0};
        vecs[3]  = '{OP_PAUSE_OFF,  0, 45, 1'b1, 1'b0, 0};
        vecs[4]  = '{OP_TICK,       1, 44, 1'b1, 1'b0, 0};
        vecs[5]  = '{OP_TICK,      34, 10, 1'b1, 1'b0, 0};
        vecs[6]  = '{OP_TICK,       1,  9, 1'b1, 1'b0, 0};
        vecs[7]  = '{OP_TICK,       8,  1, 1'b1, 1'b0, 0};
        vecs[8]  = '{OP_TICK,       1,  0, 1'b0, 1'b1, 1};
        vecs[9]  = '{OP_TICK,       2,  0, 1'b0, 1'b1, 1};
        vecs[10] = '{OP_START,      0, 60, 1'b1, 1'b0, 1};
        vecs[11] = '{OP_TICK,      30, 30, 1'b1, 1'b0, 1};

        // ---- reset with slow_clk already high: no spurious tick ----
        reset         = 1'b1;
        bus.slow_clk  = 1'b1;
        bus.start     = 1'b0;
        bus.pause     = 1'b0;
        bus0.slow_clk = 1'b0;
        bus0.start    = 1'b0;
        bus0.pause    = 1'b0;
        pause_m       = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("tick after release", {7'd0, bus.tick}, 8'd0);
        end
        chk_cnt("reset value", 60);
        chk("reset running", {7'd0, bus.running}, 8'd0);
        chk("reset done", {7'd0, bus.done}, 8'd0);
        bus.slow_clk = 1'b0;
        repeat (6) step();
        chk("tick on falling edge", {7'd0, bus.tick}, 8'd0);

        // ---- start pulse, then exact tick/decrement timing ----
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start running", {7'd0, bus.running}, 8'd1);
        chk_cnt("after start", 60);
        bus.slow_clk = 1'b1;              // first sampled at the next edge (N)
        step();
        chk("tick at N", {7'd0, bus.tick}, 8'd0);
        step();
        chk("tick at N+1", {7'd0, bus.tick}, 8'd0);
        step();
        chk("tick at N+2", {7'd0, bus.tick}, 8'd1);
        chk_cnt("digits at N+2", 60);
        step();
        chk("tick at N+3", {7'd0, bus.tick}, 8'd0);
        chk_cnt("digits at N+3", 59);
        repeat (6) step();
        bus.slow_clk = 1'b0;
        repeat (10) step();
        model_cnt = 59;
        model_run = 1'b1;

        // ---- table-driven round: pause, wrap, expiry, restart ----
        for (int v = 0; v < 12; v++) begin
            case (vecs[v].op)
                OP_TICK: begin
                    for (int r = 0; r < vecs[v].reps; r++) begin
                        slow_period();
                        if (model_run && !pause_m) begin
                            model_cnt--;
                            if (model_cnt == 0) model_run = 1'b0;
                        end
                        chk_cnt($sformatf("vec%0d step%0d", v, r), model_cnt);
                    end
                end
                OP_PAUSE_ON, OP_PAUSE_OFF: begin
                    pause_m   = (vecs[v].op == OP_PAUSE_ON);
                    bus.pause = pause_m;
                    repeat (2) step();
                end
                OP_START: begin
                    bus.start = 1'b1;
                    step();
                    bus.start = 1'b0;
                    step();
                    model_cnt = 60;
                    model_run = 1'b1;
                end
                default: ;
            endcase
            chk_cnt($sformatf("vec%0d end", v), vecs[v].exp_cnt);
            chk($sformatf("vec%0d running", v), {7'd0, bus.running}, {7'd0, vecs[v].exp_run});
            chk($sformatf("vec%0d done", v), {7'd0, bus.done}, {7'd0, vecs[v].exp_done});
            chk($sformatf("vec%0d time_up count", v), 8'(tu_cnt), 8'(vecs[v].exp_tu));
        end

        // ---- start coinciding with tick at 30: reload wins ----
        bus.slow_clk = 1'b1;
        repeat (3) step();
        chk("tick before start", {7'd0, bus.tick}, 8'd1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk_cnt("start+tick", 60);
        chk("start+tick running", {7'd0, bus.running}, 8'd1);
        step();
        chk_cnt("start+tick hold", 60);
        repeat (5) step();
        bus.slow_clk = 1'b0;
        repeat (10) step();
        model_cnt = 60;

        for (int r = 0; r < 38; r++) begin
            slow_period();
            model_cnt--;
            chk_cnt($sformatf("to22 step%0d", r), model_cnt);
        end

        // ---- asynchronous reset at 22, while tick is high ----
        bus.slow_clk = 1'b1;
        repeat (3) step();
        chk("tick before reset", {7'd0, bus.tick}, 8'd1);
        #2 reset = 1'b1;
        #1;
        chk_cnt("async reset", 60);
        chk("async reset tick", {7'd0, bus.tick}, 8'd0);
        chk("async reset running", {7'd0, bus.running}, 8'd0);
        chk("async reset done", {7'd0, bus.done}, 8'd0);
        chk("async reset time_up", {7'd0, bus.time_up}, 8'd0);
        bus.slow_clk = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        repeat (5) step();
        chk("idle after reset", {7'd0, bus.running}, 8'd0);
        chk_cnt("idle after reset", 60);

        // ---- zero-length round ----
        chk("zero reset digits", {bus0.tens, bus0.ones}, 8'h00);
        bus0.start = 1'b1;
        step();
        bus0.start = 1'b0;
        chk("zero done", {7'd0, bus0.done}, 8'd1);
        chk("zero time_up", {7'd0, bus0.time_up}, 8'd1);
        chk("zero running", {7'd0, bus0.running}, 8'd0);
        chk("zero digits", {bus0.tens, bus0.ones}, 8'h00);
        step();
        chk("zero time_up drop", {7'd0, bus0.time_up}, 8'd0);
        chk("zero done hold", {7'd0, bus0.done}, 8'd1);
        repeat (3) step();
        chk("zero time_up count", 8'(tu0_cnt), 8'd1);
        chk("zero running ever", {7'd0, run0_seen}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/score_tick_timer.md
# score_tick_timer

Receiving end of the score slow-clock path. Takes the free-running toggling `slow_clk` produced by the score clock divider, synchronises it into the `clk` domain and converts each rising edge into a one-cycle `tick` enable. It drives the whack-a-mole round timer: a two-digit BCD countdown with start/pause control and a single-cycle `time_up` pulse for the game FSM and score logic. All state is in the `clk` domain; `slow_clk` is never used as a clock.

## Interface
- `TENS_INIT`, default 6: BCD tens digit loaded on start, 0..9.
- `ONES_INIT`, default 0: BCD ones digit loaded on start, 0..9.
- `SYNC_STAGES`, default 2: synchroniser depth, at least 2.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-high.
- `slow_clk` in 1: toggling tick source from the clock divider, asynchronous to `clk`.
- `start` in 1: level; sampled each cycle, (re)loads and runs the timer.
- `pause` in 1: level; while high, the countdown is frozen.
- `tick` out 1: registered one-cycle pulse per synchronised `slow_clk` rising edge.
- `tens` out 4: BCD tens digit.
- `ones` out 4: BCD ones digit.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE.
- `time_up` out 1: one-cycle pulse on entry to DONE.

## Operation
- Synchroniser: `SYNC_STAGES` flops on `slow_clk`, followed by one history flop. The rising-edge condition is last stage high while the history flop is low. `tick` registers this condition.
- Prime counter: for the first `SYNC_STAGES`+1 cycles after reset deassert, `tick` is forced low. This prevents a spurious edge when `slow_clk` is already high at reset release.
- `tick` is generated in every state. Only RUN consumes it.
- FSM states are IDLE, RUN, PAUSED and DONE.
  - IDLE: when `start` is high, load the digits and go to RUN. Otherwise hold.
  - RUN: `start` high reloads the digits and stays in RUN; this takes priority over `tick` and `pause`. `pause` high goes to PAUSED; any tick in that cycle is dropped. `tick` high decrements the count.
  - PAUSED: `start` high reloads the digits and goes to RUN. `pause` low returns to RUN. Ticks are dropped.
  - DONE: `start` high reloads the digits and goes to RUN. Otherwise hold at 00.
- BCD decrement:
  - If `ones` is 0, `ones` becomes 9 and `tens` is decremented.
  - Otherwise `ones` is decremented.
  - Digits never leave 0..9.
- Decrementing from 01 (`tens`=0, `ones`=1) loads 00, enters DONE and pulses `time_up`.
- Zero-length round: if `TENS_INIT`=`ONES_INIT`=0, `start` from IDLE goes directly to DONE with a `time_up` pulse. RUN is never entered.
- Decrement in RUN at 00 cannot occur. The implementation asserts in simulation if it does.
- Reset, asynchronous at any time including mid-round:
  - State goes to IDLE.
  - Sync, history and prime flops clear.
  - `tens`/`ones` load `TENS_INIT`/`ONES_INIT`.
  - `tick`, `running`, `done` and `time_up` go to 0.

## Timing
- `slow_clk` rising edge first sampled at clk edge N. `tick` is high for the cycle after edge N+`SYNC_STAGES` (N+2 by default). The digits update at edge N+`SYNC_STAGES`+1.
- Worst-case tick latency is `SYNC_STAGES`+2 clk cycles, including one cycle of sampling uncertainty.
- `slow_clk` high and low phases must each be at least `SYNC_STAGES`+1 clk cycles. The divider guarantees millions. One `tick` is produced per `slow_clk` period; falling edges produce nothing.
- `start` sampled at edge K: the loaded digits and `running` are visible after edge K.
- The final decrement and the entry to DONE happen on the same edge. `time_up` and `done` rise together. `time_up` is high for exactly one cycle; `done` stays high until `start` or `reset`.
- `running` and `done` are registered decodes of the state; they are never both high.
- Holding `start` high keeps reloading each cycle, so the count does not advance. The game FSM must pulse `start`.

## Test plan
- Reset with `slow_clk` held high, release, then wait 10 cycles -> `tick` stays 0, `tens`=6, `ones`=0, `running`=0.
- With `slow_clk` period 20 clk cycles, pulse `start` -> count reads 60, 59, 58, …, 01, then 00. Each step lands 3 cycles after a `slow_clk` rise. `time_up` is a single pulse coincident with `done` rising.
- At 10, apply one `tick` -> 09, confirming the `ones` wrap to 9 and the `tens` borrow.
- Assert `pause` for 3 tick periods at 45 -> count holds at 45 and `running`=0. Release -> the next tick gives 44.
- `start` and `tick` in the same cycle at 30 -> digits become 60, no decrement. Reset mid-round at 22 -> asynchronous return to 60, IDLE, all pulses 0.
- With `TENS_INIT`=0 and `ONES_INIT`=0, pulse `start` -> DONE after one edge, `time_up` is one cycle, `running` is never high.
